// File: rtl/rng_source.sv
// Random-value producer: free-running 16-bit Galois LFSR mapped into [MIN_VAL, MIN_VAL+RANGE-1]
// by rejection, plus a push-button debouncer. Optional RNG_BUTTON_STIR_EN mixes press timing in.
module rng_source #(
  parameter int unsigned RANGE           = 6,
  parameter int unsigned MIN_VAL         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [15:0] RESET_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button_raw,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        rng_button,
  output logic        release_pulse,
  output logic [3:0]  rng_value
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MinVal = 4'(MIN_VAL);

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            btn_d, pulse_d;
  logic            sync1_q, bsync_q;
  logic [15:0]     lfsr_q, lfsr_d, lfsr_step;
  logic [3:0]      cand, value_d;

  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign cand      = lfsr_q[3:0];

`ifdef RNG_BUTTON_STIR_EN
  logic [7:0]  press_ctr_q;
  logic        press_accept;
  logic [15:0] stirred;

  assign press_accept = (state_q == StPressWait) && bsync_q && (cnt_q == CntLast);
  assign stirred      = lfsr_step ^ {press_ctr_q, press_ctr_q};

  always_ff @(posedge clk) begin
    if (rst) press_ctr_q <= '0;
    else     press_ctr_q <= press_ctr_q + 8'd1;
  end
`endif

  // seed_load wins over stirring; a zero result is never allowed into the LFSR.
  always_comb begin
    lfsr_d = lfsr_step;
`ifdef RNG_BUTTON_STIR_EN
    if (press_accept) lfsr_d = (stirred == 16'h0000) ? RESET_SEED : stirred;
`endif
    if (seed_load) lfsr_d = (seed == 16'h0000) ? RESET_SEED : seed;
  end

  always_comb begin
    value_d = rng_value;
    if (32'(cand) < RANGE) value_d = MinVal + cand;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = rng_button;
    pulse_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bsync_q) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!bsync_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          btn_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!bsync_q) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        // A bounce back high returns to the pressed state without a release.
        if (bsync_q) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          btn_d   = 1'b0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q        <= RESET_SEED;
      rng_value     <= MinVal;
      rng_button    <= 1'b0;
      release_pulse <= 1'b0;
      sync1_q       <= 1'b0;
      bsync_q       <= 1'b0;
      state_q       <= StIdle;
      cnt_q         <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      rng_value     <= value_d;
      rng_button    <= btn_d;
      release_pulse <= pulse_d;
      sync1_q       <= button_raw;
      bsync_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rng_source.sv
// Scoreboard bench for rng_source: stimulus queues expected values/events, a monitor pops and
// compares them at the falling clock edge.
module tb_rng_source;

  logic        clk = 1'b0;
  logic        rst, button_raw, seed_load;
  logic [15:0] seed;
  logic        rng_button, release_pulse;
  logic [3:0]  rng_value;
  logic        rng_button2, release_pulse2;
  logic [3:0]  rng_value2;

  always #5 clk = ~clk;

  rng_source #(.RANGE(6), .MIN_VAL(1), .DEBOUNCE_CYCLES(4), .RESET_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .button_raw(button_raw), .seed_load(seed_load), .seed(seed),
    .rng_button(rng_button), .release_pulse(release_pulse), .rng_value(rng_value)
  );

  rng_source #(.RANGE(16), .MIN_VAL(0), .DEBOUNCE_CYCLES(4), .RESET_SEED(16'hACE1)) dut_full (
    .clk(clk), .rst(rst), .button_raw(button_raw), .seed_load(seed_load), .seed(seed),
    .rng_button(rng_button2), .release_pulse(release_pulse2), .rng_value(rng_value2)
  );

  typedef struct {int cyc; int sel; logic [3:0] exp; string name;} chk_t;
  typedef struct {int cyc; logic lvl; string name;} ev_t;

  chk_t chk_q[$];
  ev_t  btn_q[$];
  ev_t  rel_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;

  // Hand-derived from ACE1 -> E270 -> 7138 -> 389C -> 1C4E -> 0E27 -> B313.
  logic [3:0] exp_def  [0:6] = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd4};
  logic [3:0] exp_full [0:6] = '{4'h1, 4'h0, 4'h8, 4'hC, 4'hE, 4'h7, 4'h3};
  // 0005 -> B402 -> 5A01 -> 9900.
  logic [3:0] exp_s5d  [0:3] = '{4'd6, 4'd3, 4'd2, 4'd1};
  logic [3:0] exp_s5f  [0:3] = '{4'h5, 4'h2, 4'h1, 4'h0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] pick(int sel);
    case (sel)
      0:       return rng_value;
      1:       return rng_value2;
      2:       return {3'b000, rng_button};
      default: return {3'b000, release_pulse};
    endcase
  endfunction

  task automatic expect_at(int c, int sel, logic [3:0] v, string name);
    chk_q.push_back('{cyc: c, sel: sel, exp: v, name: name});
  endtask

  task automatic expect_seq(int first);
    for (int i = 0; i < 7; i++) begin
      expect_at(first + i, 0, exp_def[i], "seq_value");
      expect_at(first + i, 1, exp_full[i], "seq_value_full");
    end
  endtask

  task automatic expect_btn(int c, logic lvl, string name);
    btn_q.push_back('{cyc: c, lvl: lvl, name: name});
  endtask

  task automatic expect_rel(int c, string name);
    rel_q.push_back('{cyc: c, lvl: 1'b1, name: name});
  endtask

  task automatic wait_cycles(int k);
    repeat (k) @(negedge clk);
  endtask

  // Monitor
  initial begin
    chk_t c;
    ev_t  e;
    logic prev_btn;
    prev_btn = 1'b0;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c = chk_q.pop_front();
        vectors++;
        if (c.cyc != cyc) begin
          miscompares++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", c.name, c.cyc, cyc);
        end else if (pick(c.sel) !== c.exp) begin
          miscompares++;
          $display("FAIL %s @%0d: got %0h, expected %0h", c.name, cyc, pick(c.sel), c.exp);
        end
      end
      if (mon_en) begin
        if (rng_button !== prev_btn) begin
          vectors++;
          if (btn_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_button @%0d: got %b, expected no change", cyc, rng_button);
          end else begin
            e = btn_q.pop_front();
            if (e.cyc != cyc || e.lvl !== rng_button) begin
              miscompares++;
              $display("FAIL %s: got %b @%0d, expected %b @%0d", e.name, rng_button, cyc,
                       e.lvl, e.cyc);
            end
          end
        end
        if (release_pulse !== 1'b0) begin
          vectors++;
          if (rel_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse @%0d: got %b, expected 0", cyc, release_pulse);
          end else begin
            e = rel_q.pop_front();
            if (e.cyc != cyc) begin
              miscompares++;
              $display("FAIL %s: got pulse @%0d, expected @%0d", e.name, cyc, e.cyc);
            end
          end
        end
        if (btn_q.size() > 0 && btn_q[0].cyc < cyc) begin
          e = btn_q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL %s: got no change, expected %b @%0d", e.name, e.lvl, e.cyc);
        end
        if (rel_q.size() > 0 && rel_q[0].cyc < cyc) begin
          e = rel_q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL %s: got no pulse, expected pulse @%0d", e.name, e.cyc);
        end
      end
      prev_btn = rng_button;
    end
  end

  // Stimulus
  initial begin
    int n;
    rst = 1'b1; button_raw = 1'b0; seed_load = 1'b0; seed = 16'h0000;
    @(negedge clk);
    n = cyc;
    expect_at(n + 1, 0, 4'd1, "reset_value");
    expect_at(n + 1, 1, 4'd0, "reset_value_full");
    expect_at(n + 1, 2, 4'd0, "reset_button");
    expect_at(n + 1, 3, 4'd0, "reset_pulse");
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    expect_seq(cyc + 1);
    wait_cycles(9);

    // Zero seed substitutes RESET_SEED.
    n = cyc;
    seed_load = 1'b1; seed = 16'h0000;
    @(negedge clk);
    seed_load = 1'b0;
    expect_seq(n + 2);
    wait_cycles(9);

    n = cyc;
    seed_load = 1'b1; seed = 16'h0005;
    @(negedge clk);
    seed_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_at(n + 2 + i, 0, exp_s5d[i], "seed5_value");
      expect_at(n + 2 + i, 1, exp_s5f[i], "seed5_value_full");
    end
    wait_cycles(6);

    // Clean press: 2 sync + 4 debounce + 1.
    n = cyc;
    button_raw = 1'b1;
    expect_btn(n + 7, 1'b1, "press_latency");
    wait_cycles(10);

    // Release bounce shorter than the debounce window.
    button_raw = 1'b0;
    wait_cycles(3);
    button_raw = 1'b1;
    wait_cycles(10);

    n = cyc;
    button_raw = 1'b0;
    expect_btn(n + 7, 1'b0, "release_latency");
    expect_rel(n + 7, "release_pulse");
    wait_cycles(10);

    // Press bounces.
    for (int k = 0; k < 2; k++) begin
      button_raw = 1'b1;
      wait_cycles(3);
      button_raw = 1'b0;
      wait_cycles(2);
    end
    wait_cycles(8);

    n = cyc;
    button_raw = 1'b1;
    expect_btn(n + 7, 1'b1, "press2_latency");
    wait_cycles(10);

    // Reset while pressed; button stays high so a fresh full debounce follows.
    n = cyc;
    rst = 1'b1;
    expect_btn(n + 1, 1'b0, "reset_pressed_button");
    expect_at(n + 1, 0, 4'd1, "reset2_value");
    expect_at(n + 1, 3, 4'd0, "reset2_pulse");
    @(negedge clk);
    rst = 1'b0;
    expect_btn(n + 8, 1'b1, "press_after_reset");
    expect_seq(n + 2);
    wait_cycles(10);

    n = cyc;
    button_raw = 1'b0;
    expect_btn(n + 7, 1'b0, "release2_latency");
    expect_rel(n + 7, "release2_pulse");
    wait_cycles(12);

    while (chk_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL pending_check %s: got nothing, expected check @%0d", chk_q[0].name,
               chk_q[0].cyc);
      void'(chk_q.pop_front());
    end
    while (btn_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL pending_button %s: got nothing, expected @%0d", btn_q[0].name, btn_q[0].cyc);
      void'(btn_q.pop_front());
    end
    while (rel_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL pending_pulse %s: got nothing, expected @%0d", rel_q[0].name, rel_q[0].cyc);
      void'(rel_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
